// File: rtl/bnn_param_loader.sv
// Configuration sequencer for the binary neuron array: buffers a byte-wide
// parameter image, then streams it into the serial chain without stalling.
module bnn_param_loader #(
  parameter int NEURONS    = 8,
  parameter int PARAM_BITS = 11,
  localparam int TOTAL     = NEURONS * PARAM_BITS,
  localparam int NBYTES    = (TOTAL + 7) / 8,
  localparam int CW        = $clog2(TOTAL + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          setup,
  output logic          param_in,
  input  logic          param_out,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] readback_ones
);

  localparam int BCW = $clog2(NBYTES + 1);
  localparam int IW  = NBYTES * 8;

  // Handshake: a byte transfers on a rising edge where byte_valid and
  // byte_ready are both high; byte_ready is high only while collecting.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t         state;
  logic [BCW-1:0] byte_cnt;
  logic [CW-1:0]  bit_cnt;
  logic [IW-1:0]  img_q;
  logic [IW-1:0]  img_next;

  // Image with the incoming byte merged into its slot; the last byte is
  // merged here so bit 0 can be launched on the same edge that accepts it.
  always_comb begin
    img_next = img_q;
    if (int'(byte_cnt) < NBYTES)
      img_next[8*int'(byte_cnt) +: 8] = byte_in;
  end

  assign byte_ready = (state == COLLECT);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      setup         <= 1'b0;
      param_in      <= 1'b0;
      byte_cnt      <= '0;
      bit_cnt       <= '0;
      readback_ones <= '0;
      img_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state         <= COLLECT;
            byte_cnt      <= '0;
            readback_ones <= '0;
          end
        end
        COLLECT: begin
          if (abort) begin
            state <= IDLE;
          end else if (byte_valid) begin
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == BCW'(NBYTES - 1)) begin
              // The buffer now acts as a right shift register; pad bits
              // beyond TOTAL are never shifted out.
              state    <= SHIFT;
              setup    <= 1'b1;
              param_in <= img_next[0];
              img_q    <= img_next >> 1;
              bit_cnt  <= '0;
            end else begin
              img_q <= img_next;
            end
          end
        end
        SHIFT: begin
          if (param_out)
            readback_ones <= readback_ones + 1'b1;
          if (bit_cnt == CW'(TOTAL - 1)) begin
            state    <= DONE;
            setup    <= 1'b0;
            param_in <= 1'b0;
          end else begin
            param_in <= img_q[0];
            img_q    <= img_q >> 1;
            bit_cnt  <= bit_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
